out_vc_status: RTL and testbench
================================

# out_vc_status

Per-output-port tracker of output-VC state and downstream credits, one instance per router output port (P0..P4). It consumes the per-port `outVCAvailableReset` vector produced by the VC allocator and the port's flit-departure and credit-return events. It produces the registered availability vector that the VC allocator uses to mask requests, and per-VC credit status for the switch allocator.

## Interface
- `V`, default `` `V `` (4): VCs per port.
- `DEPTH`, default `` `BUF_DEPTH `` (4): flit slots per downstream input VC; initial and maximum credit count.
- `CW`, default `$clog2(DEPTH+1)`: credit counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `outVCAvailableReset` in V: one-hot or zero; bit v means the VC allocator granted output VC v this cycle.
- `flit_valid` in 1: a flit leaves this port this cycle.
- `flit_vc` in clog2(V): output VC of the departing flit.
- `flit_is_tail` in 1: the departing flit is a tail, or a head+tail single-flit packet.
- `credit_valid` in 1: a credit returns from downstream this cycle.
- `credit_vc` in clog2(V): VC of the returned credit.
- `outVCAvailable` out V: bit v is 1 iff VC v is IDLE (registered).
- `creditNonZero` out V: bit v is 1 iff credit[v] > 0 (registered).
- `creditCount` out V*CW: credit[v] at bits [v*CW +: CW].
- `protocolErr` out 1: sticky protocol-violation flag.

## Operation
- Each VC has a 2-bit FSM with states IDLE, ACTIVE and DRAIN, plus a CW-bit credit counter.
- IDLE -> ACTIVE when `outVCAvailableReset[v]` = 1.
- ACTIVE -> DRAIN on a tail flit for v, if the next credit count is below DEPTH.
- ACTIVE -> IDLE directly on a tail flit for v if the next credit count equals DEPTH. This happens when a tail and a credit for v coincide while credit = DEPTH.
- DRAIN -> IDLE when the next credit count equals DEPTH.
- Credit next-state: next = credit − (flit on v) + (credit on v). A flit and a credit on the same VC in the same cycle leave the count unchanged.
- Violations set `protocolErr`, which stays set until `rst`:
  - A grant to a non-IDLE VC: the FSM stays in its current state.
  - A flit on an IDLE or DRAIN VC, or a flit with credit = 0: no decrement, no state change.
  - A credit that would push the count above DEPTH: the count saturates at DEPTH.
- Body flits leave the state unchanged. A grant and a tail for the same VC in the same cycle is a violation, because the VC is IDLE at grant time.
- All outputs come directly from registers; there are no combinational paths from inputs to outputs.

## Timing
- Reset values: every VC IDLE, credit = DEPTH, `outVCAvailable` = all ones, `creditNonZero` = all ones, `creditCount` = DEPTH in every field, `protocolErr` = 0.
- Reset asserted mid-packet discards all state on the next edge. Inputs are ignored while `rst` = 1.
- Grant at edge t: `outVCAvailable[v]` = 0 from t+1. The VC allocator sees the VC as taken in the following cycle, so no VC is double-granted.
- Last credit at edge t: `outVCAvailable[v]` = 1 from t+1.
- Flit at edge t: `creditCount` and `creditNonZero` are updated from t+1, a one-cycle credit loop.
- A credit returned at edge t can be used by a flit at edge t+1.

## Structure
- Add `` `BUF_DEPTH `` and the state encodings (`OVC_IDLE`=0, `OVC_ACTIVE`=1, `OVC_DRAIN`=2) to the shared `params.vh`.
- Sub-module `ovc_slot`: one VC's FSM and credit counter, with decoded 1-bit inputs grant/flit/tail/credit and an error pulse out. It is instantiated V times in a generate loop.
- The top level decodes `flit_vc`/`credit_vc`, ORs the error pulses into the sticky `protocolErr` register, and packs the outputs.

## Test plan
- **Reset:** after `rst` pulse -> `outVCAvailable`=4'b1111, each credit=4, `protocolErr`=0.
- **3-flit packet on VC2:**
  - Stimulus: grant VC2 at t0; flits at t1, t2, t3, with tail at t3; credits back at t5, t6, t7.
  - Expected: `outVCAvailable`=4'b1011 from t1; credit[2] steps 3,2,1; DRAIN after t3; credit back to 4 after t7; available again from t8.
- **Credit exhaustion on VC0:**
  - Stimulus: 4 body flits with no credits returned.
  - Expected: credit[0]=0 and `creditNonZero[0]`=0; a 5th flit -> `protocolErr`=1 with credit still 0.
- **Simultaneous flit and credit on VC1** (ACTIVE, credit=2): count stays 2. A tail plus credit at credit=4 -> VC1 goes IDLE directly, with no DRAIN cycle.
- **Illegal events:**
  - Grant to an ACTIVE VC3 -> `protocolErr`=1, VC3 stays ACTIVE.
  - Credit on VC0 with count=4 -> count stays 4, `protocolErr`=1.
- **Reset mid-packet:** VC1 ACTIVE with credit=1; assert `rst` -> next cycle VC1 IDLE, credit=4, `protocolErr`=0.

Source files
------------

// File: rtl/out_vc_status_pkg.sv
// -----------------------------------------------------------------------------
// out_vc_status_pkg
// Shared definitions for the output-VC status tracker:
//   OVC_V          - VCs per output port (default 4)
//   OVC_BUF_DEPTH  - flit slots per downstream input VC (default 4)
//   ovc_state_e    - per-VC FSM encoding (IDLE=0, ACTIVE=1, DRAIN=2)
// -----------------------------------------------------------------------------
package out_vc_status_pkg;

  localparam int OVC_V         = 4;
  localparam int OVC_BUF_DEPTH = 4;

  typedef enum logic [1:0] {
    OVC_IDLE   = 2'd0,
    OVC_ACTIVE = 2'd1,
    OVC_DRAIN  = 2'd2
  } ovc_state_e;

endpackage : out_vc_status_pkg

// File: rtl/out_vc_status_slot.sv
// -----------------------------------------------------------------------------
// out_vc_status_slot (ovc_slot)
// One output VC: a 3-state FSM (IDLE/ACTIVE/DRAIN) plus a downstream credit
// counter.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   grant_i      - VC allocator granted this VC this cycle
//   flit_i       - a flit for this VC leaves the port this cycle
//   tail_i       - the departing flit is a tail (qualifies flit_i)
//   credit_i     - a credit for this VC returns this cycle
//   avail_o      - registered: VC is IDLE
//   nonzero_o    - registered: credit count > 0
//   cnt_o        - registered credit count
//   err_o        - combinational pulse: protocol violation this cycle
// -----------------------------------------------------------------------------
module ovc_slot
  import out_vc_status_pkg::*;
#(
  parameter int DEPTH = OVC_BUF_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          grant_i,
  input  logic          flit_i,
  input  logic          tail_i,
  input  logic          credit_i,
  output logic          avail_o,
  output logic          nonzero_o,
  output logic [CW-1:0] cnt_o,
  output logic          err_o
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  ovc_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          avail_q, avail_d;
  logic          nonzero_q, nonzero_d;

  logic flit_ok;
  logic flit_err;
  logic grant_err;
  logic cred_over;

  always_comb begin
    // A flit is only legal on an ACTIVE VC that still holds a credit.
    flit_ok   = flit_i && (state_q == OVC_ACTIVE) && (cnt_q != '0);
    flit_err  = flit_i && !flit_ok;
    grant_err = grant_i && (state_q != OVC_IDLE);
    // The count can only overflow when it is already full and no legal flit
    // consumes a slot in the same cycle.
    cred_over = credit_i && (cnt_q == FULL) && !flit_ok;

    cnt_d = cnt_q;
    if (flit_ok)               cnt_d = cnt_d - CW'(1);
    if (credit_i && !cred_over) cnt_d = cnt_d + CW'(1);

    state_d = state_q;
    unique case (state_q)
      OVC_IDLE: begin
        if (grant_i) state_d = OVC_ACTIVE;
      end
      OVC_ACTIVE: begin
        // A tail that coincides with a credit returning the count to full
        // skips DRAIN entirely.
        if (flit_ok && tail_i) state_d = (cnt_d == FULL) ? OVC_IDLE : OVC_DRAIN;
      end
      OVC_DRAIN: begin
        if (cnt_d == FULL) state_d = OVC_IDLE;
      end
      default: state_d = OVC_IDLE;
    endcase

    avail_d   = (state_d == OVC_IDLE);
    nonzero_d = (cnt_d != '0);
    err_o     = grant_err | flit_err | cred_over;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= OVC_IDLE;
      cnt_q     <= FULL;
      avail_q   <= 1'b1;
      nonzero_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      avail_q   <= avail_d;
      nonzero_q <= nonzero_d;
    end
  end

  assign avail_o   = avail_q;
  assign nonzero_o = nonzero_q;
  assign cnt_o     = cnt_q;

endmodule : ovc_slot

// File: rtl/out_vc_status.sv
// -----------------------------------------------------------------------------
// out_vc_status
// Per-output-port tracker of output-VC state and downstream credits.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   outVCAvailableReset   - one-hot grant vector from the VC allocator
//   flit_valid/vc/is_tail - flit departure on this port
//   credit_valid/vc       - credit returned from downstream
//   outVCAvailable        - registered, bit v set iff VC v is IDLE
//   creditNonZero         - registered, bit v set iff credit[v] > 0
//   creditCount           - credit[v] at [v*CW +: CW]
//   protocolErr           - sticky protocol-violation flag (cleared by rst)
// -----------------------------------------------------------------------------
module out_vc_status
  import out_vc_status_pkg::*;
#(
  parameter int V     = OVC_V,
  parameter int DEPTH = OVC_BUF_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int VW    = (V > 1) ? $clog2(V) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [V-1:0]    outVCAvailableReset,
  input  logic            flit_valid,
  input  logic [VW-1:0]   flit_vc,
  input  logic            flit_is_tail,
  input  logic            credit_valid,
  input  logic [VW-1:0]   credit_vc,
  output logic [V-1:0]    outVCAvailable,
  output logic [V-1:0]    creditNonZero,
  output logic [V*CW-1:0] creditCount,
  output logic            protocolErr
);

  logic [V-1:0] flit_dec;
  logic [V-1:0] credit_dec;
  logic [V-1:0] err_vec;
  logic         protocol_err_q, protocol_err_d;

  always_comb begin
    flit_dec   = '0;
    credit_dec = '0;
    // Out-of-range VC indices (only possible when V is not a power of two)
    // decode to nothing.
    if (flit_valid && (int'(flit_vc) < V))     flit_dec[flit_vc]     = 1'b1;
    if (credit_valid && (int'(credit_vc) < V)) credit_dec[credit_vc] = 1'b1;
    protocol_err_d = protocol_err_q | (|err_vec);
  end

  for (genvar v = 0; v < V; v++) begin : g_slot
    ovc_slot #(
      .DEPTH (DEPTH),
      .CW    (CW)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .grant_i   (outVCAvailableReset[v]),
      .flit_i    (flit_dec[v]),
      .tail_i    (flit_is_tail),
      .credit_i  (credit_dec[v]),
      .avail_o   (outVCAvailable[v]),
      .nonzero_o (creditNonZero[v]),
      .cnt_o     (creditCount[v*CW +: CW]),
      .err_o     (err_vec[v])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) protocol_err_q <= 1'b0;
    else     protocol_err_q <= protocol_err_d;
  end

  assign protocolErr = protocol_err_q;

endmodule : out_vc_status

// File: tb/tb_out_vc_status.sv
// -----------------------------------------------------------------------------
// tb_out_vc_status
// Directed self-checking bench for out_vc_status (V=4, DEPTH=4, CW=3).
// -----------------------------------------------------------------------------
module tb_out_vc_status;

  localparam int V  = 4;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [V-1:0]    outVCAvailableReset;
  logic            flit_valid;
  logic [1:0]      flit_vc;
  logic            flit_is_tail;
  logic            credit_valid;
  logic [1:0]      credit_vc;
  logic [V-1:0]    outVCAvailable;
  logic [V-1:0]    creditNonZero;
  logic [V*CW-1:0] creditCount;
  logic            protocolErr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  out_vc_status dut (
    .clk                 (clk),
    .rst                 (rst),
    .outVCAvailableReset (outVCAvailableReset),
    .flit_valid          (flit_valid),
    .flit_vc             (flit_vc),
    .flit_is_tail        (flit_is_tail),
    .credit_valid        (credit_valid),
    .credit_vc           (credit_vc),
    .outVCAvailable      (outVCAvailable),
    .creditNonZero       (creditNonZero),
    .creditCount         (creditCount),
    .protocolErr         (protocolErr)
  );

  // One clock cycle with the given inputs; outputs are then sampled #1 after
  // the edge and inputs return to idle.
  task automatic step(input logic [V-1:0] g, input logic fv, input logic [1:0] fvc,
                      input logic ft, input logic cv, input logic [1:0] cvc);
    outVCAvailableReset = g;
    flit_valid = fv; flit_vc = fvc; flit_is_tail = ft;
    credit_valid = cv; credit_vc = cvc;
    @(posedge clk); #1;
    outVCAvailableReset = '0;
    flit_valid = 1'b0; flit_vc = '0; flit_is_tail = 1'b0;
    credit_valid = 1'b0; credit_vc = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step('0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (outVCAvailable !== 4'b1111) begin
      n_fail++; $display("FAIL reset_avail got %b want %b", outVCAvailable, 4'b1111);
    end
    n_tests++;
    if (creditNonZero !== 4'b1111) begin
      n_fail++; $display("FAIL reset_nonzero got %b want %b", creditNonZero, 4'b1111);
    end
    n_tests++;
    if (creditCount !== 12'b100_100_100_100) begin
      n_fail++; $display("FAIL reset_credits got %h want %h", creditCount, 12'b100_100_100_100);
    end
    n_tests++;
    if (protocolErr !== 1'b0) begin
      n_fail++; $display("FAIL reset_err got %b want 0", protocolErr);
    end
  endtask

  task automatic test_packet_vc2();
    logic [CW-1:0] exp_cnt [3] = '{3'd3, 3'd2, 3'd1};
    do_reset();
    step(4'b0100, 0, 0, 0, 0, 0);
    n_tests++;
    if (outVCAvailable !== 4'b1011) begin
      n_fail++; $display("FAIL pkt_grant_avail got %b want %b", outVCAvailable, 4'b1011);
    end
    for (int i = 0; i < 3; i++) begin
      step('0, 1, 2'd2, (i == 2), 0, 0);
      n_tests++;
      if (creditCount[2*CW +: CW] !== exp_cnt[i]) begin
        n_fail++; $display("FAIL pkt_flit%0d_credit got %0d want %0d", i, creditCount[2*CW +: CW], exp_cnt[i]);
      end
    end
    step('0, 0, 0, 0, 0, 0);
    n_tests++;
    if (outVCAvailable !== 4'b1011) begin
      n_fail++; $display("FAIL pkt_drain_avail got %b want %b", outVCAvailable, 4'b1011);
    end
    step('0, 0, 0, 0, 1, 2'd2);
    step('0, 0, 0, 0, 1, 2'd2);
    n_tests++;
    if (outVCAvailable !== 4'b1011 || creditCount[2*CW +: CW] !== 3'd3) begin
      n_fail++; $display("FAIL pkt_drain_partial got avail %b cnt %0d want 1011 3", outVCAvailable, creditCount[2*CW +: CW]);
    end
    step('0, 0, 0, 0, 1, 2'd2);
    n_tests++;
    if (outVCAvailable !== 4'b1111 || creditCount[2*CW +: CW] !== 3'd4) begin
      n_fail++; $display("FAIL pkt_release got avail %b cnt %0d want 1111 4", outVCAvailable, creditCount[2*CW +: CW]);
    end
    n_tests++;
    if (protocolErr !== 1'b0) begin
      n_fail++; $display("FAIL pkt_err got %b want 0", protocolErr);
    end
  endtask

  task automatic test_exhaust_vc0();
    do_reset();
    step(4'b0001, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step('0, 1, 2'd0, 0, 0, 0);
    n_tests++;
    if (creditCount[0 +: CW] !== 3'd0 || creditNonZero[0] !== 1'b0 || protocolErr !== 1'b0) begin
      n_fail++; $display("FAIL exh_empty got cnt %0d nz %b err %b want 0 0 0", creditCount[0 +: CW], creditNonZero[0], protocolErr);
    end
    step('0, 1, 2'd0, 0, 0, 0);
    n_tests++;
    if (protocolErr !== 1'b1 || creditCount[0 +: CW] !== 3'd0) begin
      n_fail++; $display("FAIL exh_overrun got err %b cnt %0d want 1 0", protocolErr, creditCount[0 +: CW]);
    end
    // A credit returned in one cycle is usable by a flit in the next.
    step('0, 0, 0, 0, 1, 2'd0);
    n_tests++;
    if (creditCount[0 +: CW] !== 3'd1 || creditNonZero[0] !== 1'b1) begin
      n_fail++; $display("FAIL exh_credit_back got cnt %0d nz %b want 1 1", creditCount[0 +: CW], creditNonZero[0]);
    end
    step('0, 1, 2'd0, 0, 0, 0);
    n_tests++;
    if (creditCount[0 +: CW] !== 3'd0) begin
      n_fail++; $display("FAIL exh_reuse got cnt %0d want 0", creditCount[0 +: CW]);
    end
  endtask

  task automatic test_simul_vc1();
    do_reset();
    step(4'b0010, 0, 0, 0, 0, 0);
    step('0, 1, 2'd1, 0, 0, 0);
    step('0, 1, 2'd1, 0, 0, 0);
    step('0, 1, 2'd1, 0, 1, 2'd1);
    n_tests++;
    if (creditCount[1*CW +: CW] !== 3'd2) begin
      n_fail++; $display("FAIL sim_flit_credit got cnt %0d want 2", creditCount[1*CW +: CW]);
    end
    step('0, 0, 0, 0, 1, 2'd1);
    step('0, 0, 0, 0, 1, 2'd1);
    n_tests++;
    if (creditCount[1*CW +: CW] !== 3'd4 || outVCAvailable[1] !== 1'b0) begin
      n_fail++; $display("FAIL sim_full_active got cnt %0d avail %b want 4 0", creditCount[1*CW +: CW], outVCAvailable[1]);
    end
    step('0, 1, 2'd1, 1, 1, 2'd1);
    n_tests++;
    if (outVCAvailable !== 4'b1111 || creditCount[1*CW +: CW] !== 3'd4 || protocolErr !== 1'b0) begin
      n_fail++; $display("FAIL sim_tail_direct_idle got avail %b cnt %0d err %b want 1111 4 0",
                         outVCAvailable, creditCount[1*CW +: CW], protocolErr);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    step(4'b1000, 0, 0, 0, 0, 0);
    step(4'b1000, 0, 0, 0, 0, 0);
    n_tests++;
    if (protocolErr !== 1'b1 || outVCAvailable[3] !== 1'b0) begin
      n_fail++; $display("FAIL ill_regrant got err %b avail3 %b want 1 0", protocolErr, outVCAvailable[3]);
    end
    // Still ACTIVE: a flit is accepted and consumes a credit.
    step('0, 1, 2'd3, 0, 0, 0);
    n_tests++;
    if (creditCount[3*CW +: CW] !== 3'd3) begin
      n_fail++; $display("FAIL ill_regrant_active got cnt %0d want 3", creditCount[3*CW +: CW]);
    end
    do_reset();
    step('0, 0, 0, 0, 1, 2'd0);
    n_tests++;
    if (protocolErr !== 1'b1 || creditCount[0 +: CW] !== 3'd4) begin
      n_fail++; $display("FAIL ill_credit_over got err %b cnt %0d want 1 4", protocolErr, creditCount[0 +: CW]);
    end
    do_reset();
    step(4'b0001, 1, 2'd0, 1, 0, 0);
    n_tests++;
    if (protocolErr !== 1'b1 || outVCAvailable[0] !== 1'b0 || creditCount[0 +: CW] !== 3'd4) begin
      n_fail++; $display("FAIL ill_grant_tail got err %b avail0 %b cnt %0d want 1 0 4",
                         protocolErr, outVCAvailable[0], creditCount[0 +: CW]);
    end
    do_reset();
    step('0, 1, 2'd2, 0, 0, 0);
    n_tests++;
    if (protocolErr !== 1'b1 || creditCount[2*CW +: CW] !== 3'd4) begin
      n_fail++; $display("FAIL ill_flit_idle got err %b cnt %0d want 1 4", protocolErr, creditCount[2*CW +: CW]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(4'b0010, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step('0, 1, 2'd1, 0, 0, 0);
    step(4'b0010, 0, 0, 0, 0, 0);
    n_tests++;
    if (creditCount[1*CW +: CW] !== 3'd1 || protocolErr !== 1'b1) begin
      n_fail++; $display("FAIL mid_setup got cnt %0d err %b want 1 1", creditCount[1*CW +: CW], protocolErr);
    end
    // Inputs held busy during reset must be ignored.
    rst = 1'b1;
    step(4'b0100, 1, 2'd1, 0, 1, 2'd0);
    rst = 1'b0;
    n_tests++;
    if (outVCAvailable !== 4'b1111 || creditCount !== 12'b100_100_100_100 || protocolErr !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got avail %b cnt %h err %b want 1111 924 0",
                         outVCAvailable, creditCount, protocolErr);
    end
  endtask

  initial begin
    rst = 1'b0;
    outVCAvailableReset = '0;
    flit_valid = 1'b0; flit_vc = '0; flit_is_tail = 1'b0;
    credit_valid = 1'b0; credit_vc = '0;
    @(negedge clk);
    test_reset();
    test_packet_vc2();
    test_exhaust_vc0();
    test_simul_vc1();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_out_vc_status
